code_uart_tx: RTL and testbench

//  Downstream consumer of the cipher processor: on each processor flag pulse, latch the 80-bit code_out word.

---
 rtl/code_tx_pkg.sv | 21 ++
 rtl/code_uart_tx_baud_tick_gen.sv | 38 +++
 rtl/code_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_code_uart_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/code_tx_pkg.sv
// Shared definitions for the code-word UART transmitter: FSM states, ASCII
// trailer constants and the clocks-per-bit calculation.
package code_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } tx_state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/code_uart_tx_baud_tick_gen.sv
// Baud counter: counts 0..DIV-1 and flags the last cycle of every bit period.
// clr restarts the count so the next cycle is count 0.
module baud_tick_gen
    import code_tx_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic msclk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge msclk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/code_uart_tx.sv
// Latches a code word on flag and sends its non-zero bytes MSB-first as 8N1 frames.
// Optional CR/LF trailer frames when CODE_TX_CRLF_EN is defined.
module code_uart_tx
    import code_tx_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600,
    parameter int NBYTES = 10
) (
    input  logic                  msclk,
    input  logic                  rst,
    input  logic [8*NBYTES-1:0]   code_word,
    input  logic                  flag,
    output logic                  tx,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int IW = $clog2(NBYTES + 1);
    localparam logic [IW-1:0] IDX_END  = IW'(NBYTES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

    tx_state_e             state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [8*NBYTES-1:0]   buf_q, buf_d;
    logic [7:0]            shift_q, shift_d;
    logic [2:0]            bit_q, bit_d;
    logic                  ovr_q, ovr_d;
    logic [7:0]            cur_byte;
    logic                  clr;
    logic                  tick;
`ifdef CODE_TX_CRLF_EN
    logic [1:0]            trl_q, trl_d;
`endif

    baud_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_baud (
        .msclk (msclk),
        .rst   (rst),
        .clr   (clr),
        .tick  (tick)
    );

    // Reads as zero once idx reaches NBYTES, which routes SCAN to the end-of-word path.
    always_comb begin
        cur_byte = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (idx_q == IW'(i)) begin
                cur_byte = buf_q[8*(NBYTES-1-i) +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        ovr_d   = ovr_q;
        clr     = 1'b0;
`ifdef CODE_TX_CRLF_EN
        trl_d   = trl_q;
`endif
        if (flag && state_q != ST_IDLE) begin
            ovr_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (flag) begin
                    buf_d   = code_word;
                    idx_d   = '0;
                    state_d = ST_SCAN;
`ifdef CODE_TX_CRLF_EN
                    trl_d   = '0;
`endif
                end
            end
            ST_SCAN: begin
                if (cur_byte != 8'h00) begin
                    shift_d = cur_byte;
                    clr     = 1'b1;
                    state_d = ST_START;
                end else begin
                    if (idx_q != IDX_END) begin
                        idx_d = idx_q + 1'b1;
                    end
                    // A zero last byte ends the word in this same SCAN cycle.
                    if (idx_q == IDX_END || idx_q == IDX_LAST) begin
`ifdef CODE_TX_CRLF_EN
                        if (trl_q != 2'd2) begin
                            shift_d = (trl_q == 2'd0) ? ASCII_CR : ASCII_LF;
                            trl_d   = trl_q + 2'd1;
                            clr     = 1'b1;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_DONE;
                        end
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
            ST_START: begin
                if (tick) begin
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (idx_q != IDX_END) begin
                        idx_d = idx_q + 1'b1;
                    end
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge msclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            ovr_q   <= 1'b0;
`ifdef CODE_TX_CRLF_EN
            trl_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            ovr_q   <= ovr_d;
`ifdef CODE_TX_CRLF_EN
            trl_q   <= trl_d;
`endif
        end
    end

    assign tx      = !(state_q == ST_START || (state_q == ST_DATA && !shift_q[0]));
    assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done    = (state_q == ST_DONE);
    assign overrun = ovr_q;

endmodule

// File: tb/tb_code_uart_tx.sv
// Bench for code_uart_tx at DIV=16: expected bytes queued at stimulus time,
// popped by a UART line decoder; table of words plus overrun/reset sequences.
module tb_code_uart_tx;

    localparam int DIV = 16;
    localparam int NB  = 10;
`ifdef CODE_TX_CRLF_EN
    localparam int TRAILER = 2 * (1 + 10 * DIV);
`else
    localparam int TRAILER = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [8*NB-1:0] code_word;
    logic            flag;
    logic            tx, busy, done, overrun;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [8*NB-1:0] word;
        int              exp_busy;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    code_uart_tx #(
        .CLK_HZ (16),
        .BAUD   (1),
        .NBYTES (NB)
    ) dut (
        .msclk     (clk),
        .rst       (rst),
        .code_word (code_word),
        .flag      (flag),
        .tx        (tx),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [8*NB-1:0] w);
        logic [7:0] b;
        for (int i = 0; i < NB; i++) begin
            b = w[8*(NB-1-i) +: 8];
            if (b != 8'h00) exp_q.push_back(b);
        end
`ifdef CODE_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    // Sends one word and times busy/done; optionally fires a second flag at sample ovr_at.
    task automatic run_word(input string tag, input logic [8*NB-1:0] w,
                            input int exp_busy, input int ovr_at);
        int busy_cnt, done_at;
        push_word(w);
        @(negedge clk);
        code_word = w;
        flag = 1'b1;
        @(negedge clk);
        flag = 1'b0;
        code_word = '0;
        busy_cnt = 0;
        done_at = 0;
        for (int s = 1; s <= 4000 && done_at == 0; s++) begin
            if (busy) busy_cnt++;
            if (done) done_at = s;
            if (s == ovr_at) begin
                code_word = ~w;
                flag = 1'b1;
            end else begin
                flag = 1'b0;
            end
            if (done_at == 0) @(negedge clk);
        end
        flag = 1'b0;
        chk({tag, "_done_latency"}, done_at, exp_busy + 1);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        chk({tag, "_done_busy"}, busy, 0);
        chk({tag, "_frames_left"}, exp_q.size(), 0);
        @(negedge clk);
        chk({tag, "_done_width"}, done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin : uart_mon
        logic [7:0] rx;
        logic       ab;
        forever begin
            @(negedge clk);
            if (!rst && tx == 1'b0) begin
                ab = 1'b0;
                rx = '0;
                repeat (DIV / 2) begin @(negedge clk); if (rst) ab = 1'b1; end
                if (!ab) chk("start_bit", tx, 0);
                for (int b = 0; b < 8; b++) begin
                    repeat (DIV) begin @(negedge clk); if (rst) ab = 1'b1; end
                    rx[b] = tx;
                end
                repeat (DIV) begin @(negedge clk); if (rst) ab = 1'b1; end
                if (!ab) begin
                    chk("stop_bit", tx, 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got %0h expected no frame", rx);
                    end else begin
                        chk("frame_byte", rx, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        vecs[0] = '{80'h3C57454C434F4D453C3B, 10 * 161 + 1};
        vecs[1] = '{80'h41000000000000000000, 160 + 10};
        vecs[2] = '{80'h00000000000000000000, 10};
        vecs[3] = '{80'h00480000690000000021, 3 * 160 + 11};
        vecs[4] = '{80'h0000000000FF00000000, 160 + 10};
        vecs[5] = '{80'h0000000000000000007E, 160 + 11};

        rst = 1'b1;
        flag = 1'b0;
        code_word = '0;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_overrun", overrun, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_word($sformatf("vec%0d", i), vecs[i].word, vecs[i].exp_busy + TRAILER, -1);
            chk($sformatf("vec%0d_overrun", i), overrun, 0);
            repeat (3) @(negedge clk);
        end

        // Second flag 50 cycles into the first frame.
        run_word("ovr", vecs[0].word, vecs[0].exp_busy + TRAILER, 52);
        chk("ovr_sticky", overrun, 1);
        repeat (5) @(negedge clk);
        chk("ovr_sticky_late", overrun, 1);

        // Reset in the DATA state of frame 3.
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h57);
        @(negedge clk);
        code_word = vecs[0].word;
        flag = 1'b1;
        @(negedge clk);
        flag = 1'b0;
        repeat (379) @(negedge clk);
        chk("rst_mid_busy_before", busy, 1);
        chk("rst_mid_frames_seen", exp_q.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_overrun", overrun, 0);
        repeat (200) @(negedge clk);
        run_word("after_rst", vecs[0].word, vecs[0].exp_busy + TRAILER, -1);

        // flag together with rst must not latch.
        @(negedge clk);
        code_word = vecs[0].word;
        flag = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        flag = 1'b0;
        rst = 1'b0;
        chk("rst_flag_busy", busy, 0);
        repeat (20) @(negedge clk);
        chk("rst_flag_busy_late", busy, 0);
        chk("rst_flag_tx", tx, 1);
        chk("rst_flag_overrun", overrun, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
